// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered flags, count, error pulses
// and either a registered-read or a first-word-fall-through output stage.
module sync_fifo_param #(
    parameter int DATA_W   = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              full_q, empty_q, af_q, ae_q, ov_q, un_q, rv_q;
    logic              flush, wr_ok, rd_ok;

    // Flags are computed from the next count so they land on the same edge as count.
    always_comb begin
        flush   = rst || clr;
        wr_ok   = wr_en && !full_q && !flush;
        rd_ok   = rd_en && !empty_q && !flush;
        count_d = flush ? '0 : count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        wptr_q    <= flush ? '0 : wptr_q + (AW+1)'(wr_ok);
        rptr_q    <= flush ? '0 : rptr_q + (AW+1)'(rd_ok);
        count_q   <= count_d;
        full_q    <= count_d == DEPTH_C;
        empty_q   <= count_d == '0;
        af_q      <= count_d >= AF_C;
        ae_q      <= count_d <= AE_C;
        ov_q      <= wr_en && full_q && !flush;
        un_q      <= rd_en && empty_q && !flush;
        rv_q      <= rd_ok;
        rd_data_q <= rst ? '0 : rd_ok ? mem[rptr_q[AW-1:0]] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_valid     = (FWFT != 0) ? !empty_q : rv_q;
    assign rd_data      = (FWFT != 0 && !empty_q) ? mem[rptr_q[AW-1:0]] : rd_data_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ov_q;
    assign underflow    = un_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard bench for a standard (8x9) and an FWFT (16x16) FIFO.
module tb_sync_fifo_param;
    logic clk = 0;
    always #5 clk = ~clk;

    logic       rst, clr, wr_en, rd_en;
    logic [8:0] wr_data, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic        rst_f, clr_f, wr_en_f, rd_en_f;
    logic [15:0] wr_data_f, rd_data_f;
    logic        rd_valid_f, full_f, empty_f, af_f, ae_f, ov_f, un_f;
    logic [4:0]  count_f;

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(16), .DEPTH(16), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst_f), .clr(clr_f), .wr_en(wr_en_f), .wr_data(wr_data_f), .rd_en(rd_en_f),
        .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ov_f), .underflow(un_f)
    );

    int n_cmp = 0, n_fail = 0;
    logic [8:0]  q[$], exp_q[$];
    logic [15:0] fq[$];
    logic [8:0]  m_last;
    logic        m_ov, m_un, f_ov, f_un;
    bit          mon_en = 0, mon_f = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of the standard FIFO and advance the reference model past the edge.
    task automatic step(input logic w, input logic [8:0] d, input logic r, input logic c, input logic rs);
        int n;
        logic [8:0] v;
        wr_en = w; wr_data = d; rd_en = r; clr = c; rst = rs;
        @(posedge clk);
        n = q.size();
        m_ov = 0; m_un = 0;
        if (rs) begin
            q.delete(); m_last = '0;
        end else if (c) q.delete();
        else begin
            m_ov = w && n == 8;
            m_un = r && n == 0;
            if (r && n > 0) begin v = q.pop_front(); exp_q.push_back(v); m_last = v; end
            if (w && n < 8) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic step_f(input logic w, input logic [15:0] d, input logic r, input logic c, input logic rs);
        int n;
        wr_en_f = w; wr_data_f = d; rd_en_f = r; clr_f = c; rst_f = rs;
        @(posedge clk);
        n = fq.size();
        f_ov = 0; f_un = 0;
        if (rs || c) fq.delete();
        else begin
            f_ov = w && n == 16;
            f_un = r && n == 0;
            if (r && n > 0) void'(fq.pop_front());
            if (w && n < 16) fq.push_back(d);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(q.size() == 8));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("almost_full", int'(almost_full), int'(q.size() >= 6));
        chk("almost_empty", int'(almost_empty), int'(q.size() <= 2));
        chk("overflow", int'(overflow), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_un));
        chk("rd_data_hold", int'(rd_data), int'(m_last));
        if (rd_valid) begin
            if (exp_q.size() == 0) chk("spurious_rd_valid", 1, 0);
            else chk("rd_data_order", int'(rd_data), int'(exp_q.pop_front()));
        end
    end

    always @(negedge clk) if (mon_f) begin
        chk("f_count", int'(count_f), fq.size());
        chk("f_full", int'(full_f), int'(fq.size() == 16));
        chk("f_empty", int'(empty_f), int'(fq.size() == 0));
        chk("f_almost_full", int'(af_f), int'(fq.size() >= 14));
        chk("f_almost_empty", int'(ae_f), int'(fq.size() <= 2));
        chk("f_overflow", int'(ov_f), int'(f_ov));
        chk("f_underflow", int'(un_f), int'(f_un));
        chk("f_rd_valid", int'(rd_valid_f), int'(fq.size() != 0));
        if (rd_valid_f && fq.size() != 0) chk("f_head", int'(rd_data_f), int'(fq[0]));
    end

    initial begin
        {wr_en_f, rd_en_f, clr_f} = 0; rst_f = 1; wr_data_f = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        mon_en = 1;
        // fill 1..8, overflow attempt, drain, underflow attempt
        for (int i = 1; i <= 8; i++) step(1, 9'(i), 0, 0, 0);
        step(1, 9'h1FF, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // five words then steady-state simultaneous traffic across the wrap
        for (int i = 0; i < 5; i++) step(1, 9'(16 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 9'(32 + i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 9'(64 + i), 0, 0, 0);
        step(1, 9'h0AA, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        step(1, 9'h0BB, 1, 0, 0);
        // flush with a concurrent write, then reset during a read
        for (int i = 0; i < 3; i++) step(1, 9'(80 + i), 0, 0, 0);
        step(1, 9'h0CC, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 9'(96 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 40) % 2) != 0 ? 75 : 25;
            step($urandom_range(0, 99) < wp, 9'($urandom), $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 149) == 0);
        end
        step(0, 0, 0, 0, 0);
        mon_en = 0;
        chk("scoreboard_drained", exp_q.size(), 0);

        step_f(0, 0, 0, 0, 1);
        mon_f = 1;
        step_f(1, 16'hBEEF, 0, 0, 0);
        step_f(0, 0, 0, 0, 0);
        step_f(0, 0, 1, 0, 0);
        step_f(0, 0, 1, 0, 0);
        for (int i = 0; i < 500; i++) begin
            int wp;
            wp = ((i / 50) % 2) != 0 ? 80 : 30;
            step_f($urandom_range(0, 99) < wp, 16'($urandom), $urandom_range(0, 99) < (100 - wp),
                   $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
        end
        mon_f = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
